// File: rtl/present_core.sv
// present_core
//
// Iterative PRESENT block-cipher encryption engine. One cipher round is
// computed per clock: round-key addition, 4-bit S-box layer and the 64-bit
// bit permutation, with the key schedule updated on the fly alongside the
// data. The whitening key of the last round is applied in a dedicated
// FINAL cycle before the ciphertext is presented on the output handshake.
//
// Parameters:
//   KEY_BITS  key length, 80 or 128
//   ROUNDS    number of full rounds, 1..31
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   plaintext/key presented by the source
//   in_ready   core can accept a block (IDLE only)
//   in_data    64-bit plaintext, bit 0 = LSB
//   in_key     KEY_BITS-bit cipher key
//   out_valid  ciphertext available (HOLD)
//   out_ready  downstream accepts ciphertext
//   out_data   64-bit ciphertext, retained after the handshake
//   busy       high while rounds are being computed (RUN and FINAL)

module present_core #(
  parameter int KEY_BITS = 80,
  parameter int ROUNDS   = 31
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [63:0]         in_data,
  input  logic [KEY_BITS-1:0] in_key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [63:0]         out_data,
  output logic                busy
);

  if (KEY_BITS != 80 && KEY_BITS != 128) begin : g_bad_key_bits
    $error("present_core: KEY_BITS must be 80 or 128");
  end

  if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
    $error("present_core: ROUNDS must be in 1..31");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FINAL = 2'd2,
    HOLD  = 2'd3
  } fsm_t;

  fsm_t                fsm_q;
  fsm_t                fsm_d;
  logic [63:0]         data_q;
  logic [KEY_BITS-1:0] key_q;
  logic [4:0]          rc_q;
  logic [63:0]         out_data_q;

  logic [63:0]         round_key;
  logic [KEY_BITS-1:0] key_rot;
  logic [KEY_BITS-1:0] key_next;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [63:0] sbox_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int n = 0; n < 16; n++) begin
      y[4*n +: 4] = sbox(x[4*n +: 4]);
    end
    return y;
  endfunction

  // Bit i lands on 16*i mod 63; bit 63 is a fixed point of the permutation.
  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 63; i++) begin
      y[(16*i) % 63] = x[i];
    end
    y[63] = x[63];
    return y;
  endfunction

  // The round key is always the top 64 bits of the key register.
  assign round_key = key_q[KEY_BITS-1 -: 64];

  // Key register rotated left by 61 bit positions.
  assign key_rot = {key_q[KEY_BITS-62:0], key_q[KEY_BITS-1:KEY_BITS-61]};

  // Key-schedule non-linearity and round-counter injection differ between
  // the two key lengths; only the matching branch is elaborated.
  if (KEY_BITS == 128) begin : g_key128
    always_comb begin
      key_next          = key_rot;
      key_next[127:124] = sbox(key_rot[127:124]);
      key_next[123:120] = sbox(key_rot[123:120]);
      key_next[66:62]   = key_rot[66:62] ^ rc_q;
    end
  end else begin : g_key80
    always_comb begin
      key_next        = key_rot;
      key_next[79:76] = sbox(key_rot[79:76]);
      key_next[19:15] = key_rot[19:15] ^ rc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // in_ready/out_valid/busy are pure state decodes, so reset returns them to
  // their idle values on the same edge that clears the state register.
  always_comb begin
    fsm_d     = fsm_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          fsm_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (rc_q == 5'(ROUNDS)) begin
          fsm_d = FINAL;
        end
      end
      FINAL: begin
        busy  = 1'b1;
        fsm_d = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          fsm_d = IDLE;
        end
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q     <= '0;
      key_q      <= '0;
      rc_q       <= '0;
      out_data_q <= '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (in_valid) begin
            data_q <= in_data;
            key_q  <= in_key;
            rc_q   <= 5'd1;
          end
        end
        RUN: begin
          data_q <= p_layer(sbox_layer(data_q ^ round_key));
          key_q  <= key_next;
          rc_q   <= rc_q + 5'd1;
        end
        FINAL: begin
          out_data_q <= data_q ^ round_key;
        end
        default: begin
        end
      endcase
    end
  end

  assign out_data = out_data_q;

endmodule

// File: tb/tb_present_core.sv
// tb_present_core
//
// Self-checking bench for present_core. Three instances share clock and
// reset: 80-bit key / 31 rounds, 128-bit key / 31 rounds and 80-bit key /
// 1 round. Expected ciphertexts come from published known-answer vectors or
// from a behavioural PRESENT model written directly from the cipher rules.

module tb_present_core;

  logic        clk;
  logic        rst;
  logic        iv   [3];
  logic        irdy [3];
  logic [63:0] id   [3];
  logic [127:0] ik  [3];
  logic        ov   [3];
  logic        ordy [3];
  logic [63:0] od   [3];
  logic        bsy  [3];

  int checks;
  int errors;

  present_core #(.KEY_BITS(80), .ROUNDS(31)) dut80 (
    .clk(clk), .rst(rst),
    .in_valid(iv[0]), .in_ready(irdy[0]), .in_data(id[0]), .in_key(ik[0][79:0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .busy(bsy[0])
  );

  present_core #(.KEY_BITS(128), .ROUNDS(31)) dut128 (
    .clk(clk), .rst(rst),
    .in_valid(iv[1]), .in_ready(irdy[1]), .in_data(id[1]), .in_key(ik[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .busy(bsy[1])
  );

  present_core #(.KEY_BITS(80), .ROUNDS(1)) dut80r1 (
    .clk(clk), .rst(rst),
    .in_valid(iv[2]), .in_ready(irdy[2]), .in_data(id[2]), .in_key(ik[2][79:0]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]), .busy(bsy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------

  function automatic logic [3:0] ref_sbox(input logic [3:0] v);
    logic [63:0] tab;
    tab = 64'h21748FE3DA09B65C;
    return tab[int'(v)*4 +: 4];
  endfunction

  function automatic logic [63:0] ref_sub(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int n = 0; n < 16; n++) y[4*n +: 4] = ref_sbox(x[4*n +: 4]);
    return y;
  endfunction

  function automatic logic [63:0] ref_perm(input logic [63:0] x);
    logic [63:0] y;
    int pos;
    y = '0;
    for (int i = 0; i < 64; i++) begin
      pos = (i == 63) ? 63 : (16 * i) % 63;
      y[pos] = x[i];
    end
    return y;
  endfunction

  function automatic logic [63:0] model(input logic [63:0] pt, input logic [127:0] key,
                                        input int kbits, input int rounds);
    logic [79:0]  k80;
    logic [127:0] k128;
    logic [63:0]  s;
    logic [63:0]  rk;
    k80  = key[79:0];
    k128 = key;
    s    = pt;
    for (int r = 1; r <= rounds; r++) begin
      rk = (kbits == 80) ? k80[79:16] : k128[127:64];
      s  = ref_perm(ref_sub(s ^ rk));
      if (kbits == 80) begin
        k80 = (k80 << 61) | (k80 >> 19);
        k80[79:76] = ref_sbox(k80[79:76]);
        k80[19:15] = k80[19:15] ^ 5'(r);
      end else begin
        k128 = (k128 << 61) | (k128 >> 67);
        k128[127:124] = ref_sbox(k128[127:124]);
        k128[123:120] = ref_sbox(k128[123:120]);
        k128[66:62] = k128[66:62] ^ 5'(r);
      end
    end
    rk = (kbits == 80) ? k80[79:16] : k128[127:64];
    return s ^ rk;
  endfunction

  // ---------------- scenario tasks ----------------

  // Submits one block, waits for the ciphertext, checks latency and value,
  // then completes the output handshake.
  task automatic encrypt_once(input int w, input logic [63:0] pt, input logic [127:0] key,
                              input int lat, input logic [63:0] exp, input string name);
    int cnt;
    @(negedge clk);
    ordy[w] = 1'b0;
    id[w]   = pt;
    ik[w]   = key;
    iv[w]   = 1'b1;
    checks++;
    if (irdy[w] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s in_ready: got %b expected 1", name, irdy[w]);
    end
    @(negedge clk);
    iv[w] = 1'b0;
    cnt = 0;
    while (ov[w] !== 1'b1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (cnt != lat) begin
      errors++;
      $display("[TB] FAIL %s latency: got %0d expected %0d", name, cnt, lat);
    end
    checks++;
    if (od[w] !== exp) begin
      errors++;
      $display("[TB] FAIL %s out_data: got %h expected %h", name, od[w], exp);
    end
    ordy[w] = 1'b1;
    @(negedge clk);
    ordy[w] = 1'b0;
    checks++;
    if (ov[w] !== 1'b0 || irdy[w] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s handshake: got out_valid=%b in_ready=%b expected 0/1",
               name, ov[w], irdy[w]);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst   = 1'b1;
    iv[0] = 1'b1;
    id[0] = 64'h0123456789ABCDEF;
    ik[0] = '0;
    repeat (2) @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      checks++;
      if (irdy[w] !== 1'b1 || ov[w] !== 1'b0 || bsy[w] !== 1'b0 || od[w] !== 64'h0) begin
        errors++;
        $display("[TB] FAIL reset_values[%0d]: got rdy=%b vld=%b busy=%b data=%h expected 1/0/0/0",
                 w, irdy[w], ov[w], bsy[w], od[w]);
      end
    end
    rst   = 1'b0;
    iv[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (bsy[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_with_valid: got busy=%b expected 0", bsy[0]);
    end
  endtask

  task automatic test_kat80();
    encrypt_once(0, 64'h0, 128'h0, 32, 64'h5579C1387B228445, "kat80_0_0");
    encrypt_once(0, 64'h0, {48'h0, {80{1'b1}}}, 32, 64'hE72C46C0F5945049, "kat80_0_1");
    encrypt_once(0, {64{1'b1}}, 128'h0, 32, 64'hA112FFC72F68417B, "kat80_1_0");
    encrypt_once(0, {64{1'b1}}, {48'h0, {80{1'b1}}}, 32, 64'h3333DCD3213210D2, "kat80_1_1");
  endtask

  task automatic test_kat128();
    logic [63:0]  pt;
    logic [127:0] key;
    encrypt_once(1, 64'h0, 128'h0, 32, 64'h96DB702A2E6900AF, "kat128_0_0");
    pt  = {$urandom(), $urandom()};
    key = {$urandom(), $urandom(), $urandom(), $urandom()};
    encrypt_once(1, pt, key, 32, model(pt, key, 128, 31), "rand128");
  endtask

  task automatic test_random80();
    logic [63:0]  pt;
    logic [127:0] key;
    for (int n = 0; n < 3; n++) begin
      pt  = {$urandom(), $urandom()};
      key = {48'h0, 16'($urandom()), $urandom(), $urandom()};
      encrypt_once(0, pt, key, 32, model(pt, key, 80, 31), "rand80");
    end
  endtask

  task automatic test_rounds1();
    logic [63:0]  pt;
    logic [127:0] key;
    encrypt_once(2, 64'h0, 128'h0, 2, model(64'h0, 128'h0, 80, 1), "r1_zero");
    pt  = {$urandom(), $urandom()};
    key = {48'h0, 16'($urandom()), $urandom(), $urandom()};
    encrypt_once(2, pt, key, 2, model(pt, key, 80, 1), "r1_rand");
  endtask

  task automatic test_backpressure();
    logic [63:0]  pt1, pt2;
    logic [127:0] k1, k2;
    int cnt;
    pt1 = {$urandom(), $urandom()};
    pt2 = {$urandom(), $urandom()};
    k1  = {48'h0, 16'($urandom()), $urandom(), $urandom()};
    k2  = {48'h0, 16'($urandom()), $urandom(), $urandom()};
    @(negedge clk);
    ordy[0] = 1'b0;
    id[0] = pt1;
    ik[0] = k1;
    iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    cnt = 0;
    while (ov[0] !== 1'b1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (cnt != 32) begin
      errors++;
      $display("[TB] FAIL bp_latency: got %0d expected 32", cnt);
    end
    // A second block waits at the source while the first is stalled.
    id[0] = pt2;
    ik[0] = k2;
    iv[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (od[0] !== model(pt1, k1, 80, 31) || ov[0] !== 1'b1 || irdy[0] !== 1'b0 || bsy[0] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold cycle %0d: got data=%h vld=%b rdy=%b busy=%b expected %h/1/0/0",
                 c, od[0], ov[0], irdy[0], bsy[0], model(pt1, k1, 80, 31));
      end
    end
    ordy[0] = 1'b1;
    @(negedge clk);
    ordy[0] = 1'b0;
    checks++;
    if (ov[0] !== 1'b0 || irdy[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_release: got vld=%b rdy=%b expected 0/1", ov[0], irdy[0]);
    end
    @(negedge clk);
    iv[0] = 1'b0;
    checks++;
    if (bsy[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_pending_accept: got busy=%b expected 1", bsy[0]);
    end
    cnt = 0;
    while (ov[0] !== 1'b1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (cnt != 32 || od[0] !== model(pt2, k2, 80, 31)) begin
      errors++;
      $display("[TB] FAIL bp_second_block: got lat=%0d data=%h expected 32/%h",
               cnt, od[0], model(pt2, k2, 80, 31));
    end
    ordy[0] = 1'b1;
    @(negedge clk);
    ordy[0] = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [63:0]  pts  [4];
    logic [127:0] keys [4];
    logic [63:0]  exp_q [$];
    logic [63:0]  exp;
    int cyc, nacc, nout, last_acc, extra;
    for (int n = 0; n < 4; n++) begin
      pts[n]  = {$urandom(), $urandom()};
      keys[n] = {48'h0, 16'($urandom()), $urandom(), $urandom()};
    end
    cyc = 0;
    nacc = 0;
    nout = 0;
    last_acc = 0;
    ordy[0] = 1'b1;
    while (nout < 4 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (ov[0] === 1'b1) begin
        checks++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'h0;
        if (od[0] !== exp) begin
          errors++;
          $display("[TB] FAIL b2b_data[%0d]: got %h expected %h", nout, od[0], exp);
        end
        nout++;
      end
      if (nacc < 4) begin
        iv[0] = 1'b1;
        id[0] = pts[nacc];
        ik[0] = keys[nacc];
      end else begin
        iv[0] = 1'b0;
      end
      if (iv[0] === 1'b1 && irdy[0] === 1'b1) begin
        if (nacc > 0) begin
          checks++;
          if (cyc - last_acc != 34) begin
            errors++;
            $display("[TB] FAIL b2b_interval[%0d]: got %0d expected 34", nacc, cyc - last_acc);
          end
        end
        last_acc = cyc;
        exp_q.push_back(model(pts[nacc], keys[nacc], 80, 31));
        nacc++;
      end
    end
    iv[0] = 1'b0;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (ov[0] === 1'b1) extra++;
    end
    ordy[0] = 1'b0;
    checks++;
    if (nout != 4 || extra != 0 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL b2b_count: got outputs=%0d extra=%0d pending=%0d expected 4/0/0",
               nout, extra, exp_q.size());
    end
  endtask

  task automatic test_reset_midrun();
    int seen;
    @(negedge clk);
    ordy[0] = 1'b1;
    id[0] = {$urandom(), $urandom()};
    ik[0] = {48'h0, 16'($urandom()), $urandom(), $urandom()};
    iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (14) @(negedge clk);
    checks++;
    if (bsy[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrun_busy: got %b expected 1", bsy[0]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (irdy[0] !== 1'b1 || ov[0] !== 1'b0 || bsy[0] !== 1'b0 || od[0] !== 64'h0) begin
      errors++;
      $display("[TB] FAIL midrun_reset: got rdy=%b vld=%b busy=%b data=%h expected 1/0/0/0",
               irdy[0], ov[0], bsy[0], od[0]);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (ov[0] === 1'b1 || bsy[0] === 1'b1) seen++;
    end
    ordy[0] = 1'b0;
    checks++;
    if (seen != 0) begin
      errors++;
      $display("[TB] FAIL midrun_discard: got %0d active cycles expected 0", seen);
    end
    encrypt_once(0, 64'h0, 128'h0, 32, 64'h5579C1387B228445, "after_reset");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    for (int w = 0; w < 3; w++) begin
      iv[w]   = 1'b0;
      id[w]   = '0;
      ik[w]   = '0;
      ordy[w] = 1'b0;
    end
    test_reset();
    test_kat80();
    test_kat128();
    test_random80();
    test_rounds1();
    test_backpressure();
    test_back_to_back();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
